// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, instruction RAM and run/halt control for the single-cycle core
module instruction_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          jump,
  input  logic          branch_success,
  input  logic [31:0]   jump_address,
  output logic [31:0]   instruction,
  output logic [31:0]   pc,
  output logic          running,
  output logic          halted,
  output logic [31:0]   retired_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] mem_q [IMEM_DEPTH];

  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        mem_we;

  // Fetch index ignores PC bits above the RAM size so fetches wrap around
  assign fetch_word = mem_q[pc_q[AW+1:2]];
  assign pc_plus4   = pc_q + 32'd4;
  // RAM is read-only while running
  assign mem_we     = load_valid && (state_q != ST_RUN);

  // Next-PC selection: jump beats branch beats sequential
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_address[25:0], 2'b00};
    end else if (branch_success) begin
      // word offset scaled to bytes; the shift drops bits 31:30 of the offset
      next_pc = pc_plus4 + (jump_address << 2);
    end
  end

  // Run/halt state machine; start always restarts from RESET_PC
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    if (start) begin
      state_d   = ST_RUN;
      pc_d      = RESET_PC;
      retired_d = 32'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (load_valid) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          state_d = ST_LOAD;
        end
        ST_RUN: begin
          if (fetch_word == HALT_WORD) begin
            state_d = ST_HALT;
          end else begin
            pc_d      = next_pc;
            retired_d = retired_q + 32'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // Instruction RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[load_addr] <= load_data;
  end

  assign instruction   = (state_q == ST_RUN) ? fetch_word : 32'h0000_0000;
  assign pc            = pc_q;
  assign running       = (state_q == ST_RUN);
  assign halted        = (state_q == ST_HALT);
  assign retired_count = retired_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam int          DEPTH = 256;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, load_valid, start, jump, branch_success;
  logic [7:0]  load_addr;
  logic [31:0] load_data, jump_address;
  logic [31:0] instruction, pc, retired_count;
  logic        running, halted;

  int checks = 0;
  int failures = 0;

  // reference model: 0=idle 1=load 2=run 3=halt
  logic [31:0] mem_m [DEPTH];
  int          st_m;
  logic [31:0] pc_m, cnt_m;

  typedef struct {
    logic [31:0] at_pc;
    logic        j;
    logic        b;
    logic [31:0] ja;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs [6];

  logic [31:0] prog [4];

  instruction_fetch_unit #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .start(start), .jump(jump),
    .branch_success(branch_success), .jump_address(jump_address),
    .instruction(instruction), .pc(pc), .running(running), .halted(halted),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] p4;
    if (!rst) begin
      st_m = 0; pc_m = 0; cnt_m = 0;
    end else if (st_m == 2) begin
      if (start) begin
        pc_m = 0; cnt_m = 0;
      end else if (mem_m[pc_m[9:2]] == HALT) begin
        st_m = 3;
      end else begin
        p4 = pc_m + 4;
        if (jump)                pc_m = {p4[31:28], jump_address[25:0], 2'b00};
        else if (branch_success) pc_m = p4 + jump_address * 4;
        else                     pc_m = p4;
        cnt_m = cnt_m + 1;
      end
    end else begin
      if (load_valid) mem_m[load_addr] = load_data;
      if (start) begin
        st_m = 2; pc_m = 0; cnt_m = 0;
      end else if (load_valid) begin
        st_m = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 1'b1; load_valid = 1'b0; start = 1'b0; jump = 1'b0;
    branch_success = 1'b0; load_addr = '0; load_data = '0; jump_address = '0;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    load_valid = 1'b1; load_addr = 8'(a); load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic check_model();
    chk("rnd_pc", pc, pc_m);
    chk("rnd_instr", instruction, (st_m == 2) ? mem_m[pc_m[9:2]] : 32'h0);
    chk("rnd_running", {31'b0, running}, {31'b0, st_m == 2});
    chk("rnd_halted", {31'b0, halted}, {31'b0, st_m == 3});
    chk("rnd_retired", retired_count, cnt_m);
  endtask

  initial begin
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003;
    prog[2] = 32'h0022_1820; prog[3] = HALT;
    vecs[0] = '{32'h10,  1'b1, 1'b0, 32'h0000_0040, 32'h100};
    vecs[1] = '{32'h10,  1'b1, 1'b1, 32'h0000_0040, 32'h100};
    vecs[2] = '{32'h20,  1'b0, 1'b1, 32'hFFFF_FFFE, 32'h1C};
    vecs[3] = '{32'h20,  1'b0, 1'b1, 32'h0000_0003, 32'h30};
    vecs[4] = '{32'h3FC, 1'b0, 1'b0, 32'h0000_0000, 32'h400};
    vecs[5] = '{32'h40,  1'b0, 1'b0, 32'h1234_5678, 32'h44};
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;

    clr();
    rst = 1'b0;
    tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_running", {31'b0, running}, 32'h0);
    chk("reset_halted", {31'b0, halted}, 32'h0);
    chk("reset_instr", instruction, 32'h0);
    chk("reset_retired", retired_count, 32'h0);
    rst = 1'b1;

    // basic program
    for (int i = 0; i < 4; i++) load_word(i, prog[i]);
    chk("load_running", {31'b0, running}, 32'h0);
    chk("load_instr", instruction, 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    chk("prog_pc0", pc, 32'h0);
    chk("prog_running", {31'b0, running}, 32'h1);
    chk("prog_instr0", instruction, prog[0]);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("prog_pc_seq", pc, 32'(k * 4));
    end
    tick();
    chk("prog_halted", {31'b0, halted}, 32'h1);
    chk("prog_retired", retired_count, 32'd3);
    chk("prog_halt_instr", instruction, 32'h0);
    chk("prog_halt_pc", pc, 32'hC);

    // reset mid-run, then re-run with RAM preserved
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("midrst_pc8", pc, 32'h8);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_instr", instruction, 32'h0);
    chk("midrst_running", {31'b0, running}, 32'h0);
    chk("midrst_halted", {31'b0, halted}, 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20 && !halted; i++) tick();
    chk("rerun_halted", {31'b0, halted}, 32'h1);
    chk("rerun_retired", retired_count, 32'd3);

    // load attempted during RUN is ignored; load in HALT goes to LOAD
    start = 1'b1; tick(); start = 1'b0;
    load_valid = 1'b1; load_addr = 8'd2; load_data = 32'hDEAD_BEEF;
    tick(); load_valid = 1'b0;
    tick();
    chk("runload_pc", pc, 32'h8);
    chk("runload_word2", instruction, prog[2]);
    tick(); tick();
    chk("runload_halted", {31'b0, halted}, 32'h1);
    load_word(2, 32'h1234_5678);
    chk("haltload_running", {31'b0, running}, 32'h0);
    chk("haltload_halted", {31'b0, halted}, 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("haltload_word2", instruction, 32'h1234_5678);

    // fill RAM with non-halt words, then next-PC vectors
    rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) load_word(i, $urandom() & 32'h7FFF_FFFF);
    for (int v = 0; v < 6; v++) begin
      start = 1'b1; tick(); start = 1'b0;
      jump = 1'b1; jump_address = vecs[v].at_pc >> 2; tick();
      chk("vec_setup_pc", pc, vecs[v].at_pc);
      jump = vecs[v].j; branch_success = vecs[v].b; jump_address = vecs[v].ja;
      tick();
      chk("vec_next_pc", pc, vecs[v].exp_pc);
      chk("vec_retired", retired_count, 32'd2);
      if (vecs[v].exp_pc == 32'h400) chk("wrap_instr", instruction, mem_m[0]);
      clr();
    end

    // randomized run against the model
    rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      load_word(i, ($urandom_range(0, 7) == 0) ? HALT : ($urandom() & 32'h7FFF_FFFF));
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 199) != 0);
      start          = ($urandom_range(0, 39) == 0);
      load_valid     = ($urandom_range(0, 7) == 0);
      load_addr      = 8'($urandom());
      load_data      = ($urandom_range(0, 7) == 0) ? HALT : $urandom();
      jump           = ($urandom_range(0, 5) == 0);
      branch_success = ($urandom_range(0, 3) == 0);
      jump_address   = $urandom_range(0, 1) ? $urandom() : 32'($signed($urandom_range(0, 40)) - 20);
      tick();
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Program-counter and instruction-memory block feeding the `MIPS_processor_debug` core. It drives the core's `instruction` input and consumes the core's `jump`, `branch_success` and `jump_address` outputs to compute the next PC. It owns a word-addressed instruction RAM that the host loads over a simple write port before execution. A run/halt state machine gates fetching.

## Interface

Parameters:
- `IMEM_DEPTH`, default 256: instruction RAM depth in 32-bit words; power of two, ≥ 4.
- `RESET_PC`, default 32'h0000_0000: byte address of the first fetch after `start`; word-aligned.
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that stops execution.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; synchronous, active-low.
- `load_valid` in 1: host write strobe into instruction RAM.
- `load_addr` in log2(IMEM_DEPTH): host write word index.
- `load_data` in 32: host write word.
- `start` in 1: begin or restart execution at `RESET_PC`.
- `jump` in 1: from core; unconditional jump this cycle.
- `branch_success` in 1: from core; taken branch this cycle.
- `jump_address` in 32: from core. On jump, bits [25:0] are the instruction index. On branch, it is the sign-extended word offset.
- `instruction` out 32: instruction presented to core.
- `pc` out 32: current PC (byte address).
- `running` out 1: high in RUN.
- `halted` out 1: high in HALT.
- `retired_count` out 32: instructions executed since last `start`.

## Operation

- States: IDLE, LOAD, RUN, HALT. Reset → IDLE.
- **IDLE**
  - `load_valid` → write RAM and go to LOAD.
  - `start` → RUN, `pc` ← RESET_PC, `retired_count` ← 0.
  - If both are high, the write happens and `start` wins (→ RUN).
- **LOAD**
  - `load_valid` writes `mem[load_addr]` ← `load_data`.
  - `start` → RUN as above.
  - The state stays LOAD otherwise.
- **RUN**
  - `instruction` = `mem[pc[k+1:2]]`, where k = log2(IMEM_DEPTH). Bits above k+1 are ignored, so the fetch index wraps modulo depth.
  - If the fetched word == HALT_WORD, go to HALT. `pc` holds and `retired_count` does not increment. Core inputs are ignored that cycle.
  - Otherwise, with `pc_plus4` = `pc` + 4, the next PC is chosen by priority:
    - `jump` → {pc_plus4[31:28], jump_address[25:0], 2'b00};
    - else `branch_success` → pc_plus4 + {jump_address[29:0], 2'b00}, mod 2^32;
    - else `pc_plus4`.
  - Then `retired_count` += 1, wrapping at 2^32.
  - `load_valid` is ignored; the RAM is read-only while running.
  - `start` → restart at RESET_PC with `retired_count` ← 0. It takes priority over the halt check and next-PC selection.
- **HALT**
  - `start` → RUN from RESET_PC, `retired_count` ← 0.
  - `load_valid` writes RAM and goes to LOAD.
  - `pc` and `retired_count` hold.
- `instruction` is forced to 32'h0000_0000 (NOP) in every state except RUN.
- PC low two bits are always 0 by construction.
- RAM contents are not cleared by reset. Contents are undefined at power-up until written.

## Timing

- Reset (sampled at rising edge with `rst`=0):
  - state = IDLE, `pc` = RESET_PC, `retired_count` = 0;
  - `running` = 0, `halted` = 0, `instruction` = 0.
- Reset mid-RUN aborts on that edge. The next cycle is IDLE with RAM preserved.
- RAM read is asynchronous: `instruction` is valid in the same cycle `pc` changes. This gives zero fetch latency and matches the single-cycle core, whose `jump`/`branch_success` are combinational from `instruction`.
- RAM write is synchronous. A word written at edge N is readable from cycle N+1.
- `pc` updates at every RUN edge: one instruction per cycle, no stalls.
- `running`/`halted` are registered state decodes and change on the edge that changes state.
- `retired_count` for a program of n non-halt instructions equals n on the cycle `halted` rises.

## Test plan

- Reset then load: load words 0..3 = 32'h2001_0005, 32'h2002_0003, 32'h0022_1820, HALT_WORD; pulse `start`.
  - Required: `pc` goes 0, 4, 8, 12.
  - `halted`=1 with `retired_count`=3 and `instruction`=0.
- Jump: in RUN at `pc`=32'h10, drive `jump`=1, `jump_address`=32'h0000_0040.
  - Required: next `pc`=32'h100.
  - `jump`=1 together with `branch_success`=1 still gives 32'h100.
- Branch: at `pc`=32'h20, drive `branch_success`=1.
  - `jump_address`=32'hFFFF_FFFE → next `pc`=32'h1C.
  - `jump_address`=32'h3 → next `pc`=32'h30.
- Wrap: IMEM_DEPTH=256, `pc`=32'h3FC with a non-halt word.
  - Next `pc`=32'h400, which fetches `mem[0]`; `instruction` equals word 0.
- Reset mid-run: assert `rst`=0 for one edge at `pc`=32'h8.
  - Required: state IDLE, `pc`=0, `instruction`=0.
  - A following `start` re-executes the original program unchanged (RAM preserved).
- Load during RUN: drive `load_valid`=1 to word 2 while running.
  - Required: RAM word 2 unchanged.
  - `load_valid` in HALT → state LOAD and the write takes effect.
